led_matrix_scan: RTL



---
 rtl/led_matrix_scan.sv | 104 ++++++++++
 1 files changed

// File: rtl/led_matrix_scan.sv
// Multiplexed LED-matrix scanner: column dwell timer, per-LED PWM, blanking at
// each column change, and a double-buffered framebuffer swapped at frame end.

module led_row_lane #(
  parameter int PWM_BITS = 4
) (
  input  logic [PWM_BITS-1:0] level,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                blank,
  output logic                lit
);
  assign lit = !blank && (duty < level);
endmodule

module led_matrix_scan #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 8,
  parameter int BITS_DIV       = 12,
  parameter int PWM_BITS       = 4,
  parameter int BLANK_CYCLES   = 16,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_col,
  input  logic [RW-1:0]       wr_row,
  input  logic [PWM_BITS-1:0] wr_level,
  input  logic                swap_req,
  output logic                swap_pending,
  output logic                frame_start,
  output logic [NUM_ROWS-1:0] leds,
  output logic [NUM_COLS-1:0] lcol
);

  localparam logic [NUM_COLS-1:0] COL_IDLE = COL_ACTIVE_LOW ? '1 : '0;
  localparam logic [BITS_DIV-1:0] BLANK_T  = BITS_DIV'(BLANK_CYCLES);
  localparam logic [CW-1:0]       LAST_COL = CW'(NUM_COLS - 1);

  logic [BITS_DIV-1:0] timer;
  logic [CW-1:0]       col;
  logic                front_sel;
  // [bank][col][row] brightness; bank front_sel is displayed, the other is written
  logic [1:0][NUM_COLS-1:0][NUM_ROWS-1:0][PWM_BITS-1:0] fb;

  logic                timer_wrap, frame_end, blank, wr_ok;
  logic [NUM_ROWS-1:0] leds_d;
  logic [NUM_COLS-1:0] sel, lcol_d;

  assign timer_wrap = &timer;
  assign frame_end  = timer_wrap && (col == LAST_COL);
  assign blank      = timer < BLANK_T;
  assign wr_ok      = wr_en
                   && ({1'b0, wr_col} < (CW+1)'(NUM_COLS))
                   && ({1'b0, wr_row} < (RW+1)'(NUM_ROWS));

  genvar r;
  generate
    for (r = 0; r < NUM_ROWS; r++) begin : g_lane
      led_row_lane #(.PWM_BITS(PWM_BITS)) u_lane (
        .level (fb[front_sel][col][r]),
        .duty  (timer[BITS_DIV-1 -: PWM_BITS]),
        .blank (blank),
        .lit   (leds_d[r])
      );
    end
  endgenerate

  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_COLS; c++) sel[c] = !blank && (col == CW'(c));
    lcol_d = COL_ACTIVE_LOW ? ~sel : sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      col          <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      frame_start  <= 1'b0;
      fb           <= '0;
      leds         <= '0;
      lcol         <= COL_IDLE;
    end else begin
      timer <= timer + 1'b1;
      if (timer_wrap) col <= (col == LAST_COL) ? '0 : col + 1'b1;
      // Writes use the pre-swap select, so a same-edge write shows in the new frame
      if (wr_ok) fb[~front_sel][wr_col][wr_row] <= wr_level;
      if (frame_end && (swap_pending || swap_req)) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      frame_start <= frame_end;
      leds        <= leds_d;
      lcol        <= lcol_d;
    end
  end

endmodule
